// File: rtl/washer_input_cond.sv
// ---------------------------------------------------------------------------
// washer_input_cond
//
// Input conditioning stage sitting in front of the washer controller.
// Raw front-panel buttons and the door switch are synchronised into the clk
// domain and debounced. Button presses become single-cycle pulses. The raw
// water level is turned into hysteretic full/empty flags. A fill watchdog
// flags a fault when filling takes too long. Every controller-facing output
// is registered.
//
// Ports:
//   clk         in   single clock
//   rstn        in   asynchronous active-low reset
//   start_btn   in   raw start button (async, active high)
//   cancel_btn  in   raw cancel button (async, active high)
//   door_sw     in   raw door switch (async, 1 = open)
//   level       in   unsigned water level, synchronous to clk
//   water_fill  in   fill valve command fed back from the controller
//   start       out  one-cycle pulse per debounced start press
//   cancel      out  one-cycle pulse per debounced cancel press
//   door_open   out  debounced door level
//   water_full  out  hysteretic full flag
//   drained     out  hysteretic empty flag
//   fill_fault  out  fill watchdog expired, sticky while water_fill is high
// ---------------------------------------------------------------------------
module washer_input_cond #(
  parameter int DEB_CYCLES   = 4,
  parameter int LEVEL_W      = 8,
  parameter int FULL_LEVEL   = 200,
  parameter int EMPTY_LEVEL  = 10,
  parameter int HYST         = 8,
  parameter int FILL_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_btn,
  input  logic               cancel_btn,
  input  logic               door_sw,
  input  logic [LEVEL_W-1:0] level,
  input  logic               water_fill,
  output logic               start,
  output logic               cancel,
  output logic               door_open,
  output logic               water_full,
  output logic               drained,
  output logic               fill_fault
);

  // Channel indices into the shared debounce vectors.
  localparam int CH_START  = 0;
  localparam int CH_CANCEL = 1;
  localparam int CH_DOOR   = 2;
  localparam int NUM_CH    = 3;

  // Debounce counter sizing. The counter only ever holds 0..DEB_CYCLES-1
  // because it clears on the cycle it would reach DEB_CYCLES, so comparing
  // against DEB_CYCLES-1 avoids any overflow at the top of the range.
  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  // Level thresholds sized to the level bus so all compares are unsigned.
  localparam logic [LEVEL_W-1:0] FULL_SET  = LEVEL_W'(FULL_LEVEL);
  localparam logic [LEVEL_W-1:0] FULL_CLR  = LEVEL_W'(FULL_LEVEL - HYST);
  localparam logic [LEVEL_W-1:0] EMPTY_SET = LEVEL_W'(EMPTY_LEVEL);
  localparam logic [LEVEL_W-1:0] EMPTY_CLR = LEVEL_W'(EMPTY_LEVEL + HYST);

  // Watchdog counter saturates at FILL_TIMEOUT.
  localparam int              WD_W    = $clog2(FILL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(FILL_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(FILL_TIMEOUT - 1);

  logic [NUM_CH-1:0]         raw_in;
  logic [NUM_CH-1:0]         sync_a;
  logic [NUM_CH-1:0]         sync_b;
  logic [NUM_CH-1:0]         deb;
  logic [NUM_CH-1:0][CW-1:0] deb_cnt;

  logic                      start_deb_d;
  logic                      cancel_deb_d;

  logic [WD_W-1:0]           wd_cnt;

  assign raw_in[CH_START]  = start_btn;
  assign raw_in[CH_CANCEL] = cancel_btn;
  assign raw_in[CH_DOOR]   = door_sw;

  // Two-flop synchronisers for the asynchronous front-panel inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_in;
      sync_b <= sync_a;
    end
  end

  // Debounce: a channel only changes once its synchronised value has
  // disagreed with the debounced value for DEB_CYCLES consecutive cycles.
  // Any cycle of agreement restarts the count, which rejects short glitches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb     <= '0;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_b[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising-edge detection on the debounced buttons gives one pulse per press;
  // holding or releasing a button never produces a further pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_deb_d  <= 1'b0;
      cancel_deb_d <= 1'b0;
      start        <= 1'b0;
      cancel       <= 1'b0;
      door_open    <= 1'b0;
    end else begin
      start_deb_d  <= deb[CH_START];
      cancel_deb_d <= deb[CH_CANCEL];
      start        <= deb[CH_START] & ~start_deb_d;
      cancel       <= deb[CH_CANCEL] & ~cancel_deb_d;
      door_open    <= deb[CH_DOOR];
    end
  end

  // Hysteretic level flags. Between the set and clear thresholds the flag
  // holds, so level noise around a threshold cannot make it chatter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      water_full <= 1'b0;
      drained    <= 1'b0;
    end else begin
      if (level >= FULL_SET) begin
        water_full <= 1'b1;
      end else if (level < FULL_CLR) begin
        water_full <= 1'b0;
      end

      if (level <= EMPTY_SET) begin
        drained <= 1'b1;
      end else if (level > EMPTY_CLR) begin
        drained <= 1'b0;
      end
    end
  end

  // Fill watchdog. The fault is raised on the same edge the counter reaches
  // FILL_TIMEOUT and only drops once the valve command goes low; reaching
  // full merely stops the count and leaves an existing fault in place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt     <= '0;
      fill_fault <= 1'b0;
    end else if (!water_fill) begin
      wd_cnt     <= '0;
      fill_fault <= 1'b0;
    end else if (water_full) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_LAST) begin
        fill_fault <= 1'b1;
      end
    end
  end

endmodule
